// File: rtl/result_fifo_pkg.sv
// Shared definitions for the result path between the add/subtract stage and its consumer.
package result_fifo_pkg;

  localparam int RESULT_WIDTH = 8;
  localparam int RESULT_DEPTH = 4;

  typedef struct packed {
    logic       sign;
    logic [7:0] data;
  } result_entry_t;

endpackage

// File: rtl/result_fifo_store.sv
// Register array holding buffered results: one write port, one asynchronous read port.
module result_store
  import result_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH,
  parameter int DEPTH = RESULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH:0] mem [DEPTH];

  // Storage is deliberately left unreset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_fifo.sv
// First-word-fall-through buffer for (result, sign) pairs with valid/ready handshake and status.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int WIDTH = RESULT_WIDTH,
  parameter int DEPTH = RESULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sign,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sign,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [WIDTH:0] head;

  // Status depends only on registered count, so in_ready has no path from out_ready.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

  result_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (push && !clear),
    .waddr (wr_ptr),
    .wdata ({in_sign, in_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign out_data = head[WIDTH-1:0];
  assign out_sign = head[WIDTH];

endmodule

// File: tb/tb_result_fifo.sv
// Directed, table-driven checks of result_fifo plus hand-written reset sequences.
module tb_result_fifo;
  import result_fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sign;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sign;
  logic       out_ready;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  result_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sign   (in_sign),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sign;
    logic       out_ready;
    logic       clear;
    logic [2:0] e_count;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_sign;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic iv, logic [7:0] d, logic s, logic ordy,
                              logic clr, logic [2:0] ec, logic ev, logic [7:0] ed,
                              logic es, logic eo);
    vec_t v;
    v.name = name; v.in_valid = iv; v.in_data = d; v.in_sign = s; v.out_ready = ordy;
    v.clear = clr; v.e_count = ec; v.e_valid = ev; v.e_data = ed; v.e_sign = es; v.e_ovf = eo;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(string name, logic [2:0] ec, logic ev, logic [7:0] ed,
                             logic es, logic eo);
    check({name, ".count"}, 32'(count), 32'(ec));
    check({name, ".full"}, 32'(full), 32'(ec == 3'd4));
    check({name, ".empty"}, 32'(empty), 32'(ec == 3'd0));
    check({name, ".in_ready"}, 32'(in_ready), 32'(ec != 3'd4));
    check({name, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({name, ".overflow"}, 32'(overflow), 32'(eo));
    if (ev) begin
      check({name, ".out_data"}, 32'(out_data), 32'(ed));
      check({name, ".out_sign"}, 32'(out_sign), 32'(es));
    end
  endtask

  task automatic drive(logic iv, logic [7:0] d, logic s, logic ordy, logic clr);
    in_valid = iv; in_data = d; in_sign = s; out_ready = ordy; clear = clr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // fill to full, head stays 0x29
    vecs.push_back(mk("fill0", 1, 8'h29, 0, 0, 0, 3'd1, 1, 8'h29, 0, 0));
    vecs.push_back(mk("fill1", 1, 8'h01, 0, 0, 0, 3'd2, 1, 8'h29, 0, 0));
    vecs.push_back(mk("fill2", 1, 8'hBA, 1, 0, 0, 3'd3, 1, 8'h29, 0, 0));
    vecs.push_back(mk("fill3", 1, 8'h4A, 0, 0, 0, 3'd4, 1, 8'h29, 0, 0));
    // overflow and drain
    vecs.push_back(mk("ovf",    1, 8'h55, 0, 0, 0, 3'd4, 1, 8'h29, 0, 1));
    vecs.push_back(mk("drain0", 0, 8'h00, 0, 1, 0, 3'd3, 1, 8'h01, 0, 1));
    vecs.push_back(mk("drain1", 0, 8'h00, 0, 1, 0, 3'd2, 1, 8'hBA, 1, 1));
    vecs.push_back(mk("drain2", 0, 8'h00, 0, 1, 0, 3'd1, 1, 8'h4A, 0, 1));
    vecs.push_back(mk("drain3", 0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00, 0, 1));
    // two entries held, then push+pop through pointer wrap
    vecs.push_back(mk("hold0", 1, 8'h0E, 0, 0, 0, 3'd1, 1, 8'h0E, 0, 1));
    vecs.push_back(mk("hold1", 1, 8'h0F, 1, 0, 0, 3'd2, 1, 8'h0E, 0, 1));
    vecs.push_back(mk("pp10",  1, 8'h10, 0, 1, 0, 3'd2, 1, 8'h0F, 1, 1));
    vecs.push_back(mk("pp11",  1, 8'h11, 1, 1, 0, 3'd2, 1, 8'h10, 0, 1));
    vecs.push_back(mk("pp12",  1, 8'h12, 0, 1, 0, 3'd2, 1, 8'h11, 1, 1));
    vecs.push_back(mk("pp13",  1, 8'h13, 1, 1, 0, 3'd2, 1, 8'h12, 0, 1));
    vecs.push_back(mk("pp14",  1, 8'h14, 0, 1, 0, 3'd2, 1, 8'h13, 1, 1));
    vecs.push_back(mk("pp15",  1, 8'h15, 1, 1, 0, 3'd2, 1, 8'h14, 0, 1));
    // full plus simultaneous in_valid and pop: pop only
    vecs.push_back(mk("top2",  1, 8'h20, 0, 0, 0, 3'd3, 1, 8'h14, 0, 1));
    vecs.push_back(mk("top3",  1, 8'h21, 1, 0, 0, 3'd4, 1, 8'h14, 0, 1));
    vecs.push_back(mk("fullpp",1, 8'h66, 0, 1, 0, 3'd3, 1, 8'h15, 1, 1));
    vecs.push_back(mk("fd0",   0, 8'h00, 0, 1, 0, 3'd2, 1, 8'h20, 0, 1));
    vecs.push_back(mk("fd1",   0, 8'h00, 0, 1, 0, 3'd1, 1, 8'h21, 1, 1));
    vecs.push_back(mk("fd2",   0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00, 0, 1));
    // clear beats a concurrent push and pop
    vecs.push_back(mk("c31",   1, 8'h31, 0, 0, 0, 3'd1, 1, 8'h31, 0, 1));
    vecs.push_back(mk("c32",   1, 8'h32, 1, 0, 0, 3'd2, 1, 8'h31, 0, 1));
    vecs.push_back(mk("c33",   1, 8'h33, 0, 0, 0, 3'd3, 1, 8'h31, 0, 1));
    vecs.push_back(mk("clear", 1, 8'h34, 1, 1, 1, 3'd0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("idle",  0, 8'h00, 0, 1, 0, 3'd0, 0, 8'h00, 0, 0));

    // reset held for 2 cycles, released between edges
    repeat (2) @(posedge clk);
    #5 rst = 1'b1;
    @(posedge clk); #1;
    check_state("reset", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].in_sign, vecs[i].out_ready, vecs[i].clear);
      @(posedge clk); #1;
      check_state(vecs[i].name, vecs[i].e_count, vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_sign, vecs[i].e_ovf);
    end

    // refill two, then asynchronous reset between edges
    drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_state("refill", 3'd2, 1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1;
    check_state("async_rst", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check_state("post_rst", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

    // operation resumes from pointer zero
    drive(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_state("resume", 3'd1, 1'b1, 8'h77, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_state("resume_pop", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Downstream stage of the arithmetic datapath: captures each (result, sign) pair emitted after the add/subtract step.
- Buffers the pairs in a small first-word-fall-through FIFO. Storage depth matches the memory B address space: 4 entries, 2-bit pointers.
- Presents buffered entries to the consumer over a valid/ready handshake, with occupancy and error status.

Parameters:
- WIDTH, 8, data width of a result word
- DEPTH, 4, number of entries (power of two)
- AW, 2, pointer width, log2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush of all contents and status
- in_valid  input  1  producer has a result this cycle
- in_data  input  WIDTH  result word
- in_sign  input  1  sign flag accompanying in_data
- in_ready  output  1  FIFO can accept an entry
- out_valid  output  1  head entry available
- out_data  output  WIDTH  head result word
- out_sign  output  1  head sign flag
- out_ready  input  1  consumer takes head this cycle
- count  output  AW+1  occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: push attempted while full

Behaviour:
- Reset (rst low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Resulting outputs: empty=1, full=0, in_ready=1, out_valid=0.
  - Storage array is not reset.
  - Reset asserted mid-transfer discards all contents immediately.
- Push and pop conditions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Ready and valid generation:
  - in_ready = !full.
  - in_ready is registered-state-derived only; no combinational path from out_ready.
  - out_valid = !empty.
  - out_data and out_sign are driven combinationally from mem[rd_ptr] (first-word fall-through).
- Latency: an entry pushed at edge k is visible on out_valid/out_data after edge k (one cycle from in_valid to out_valid).
- Push: on the rising edge, mem[wr_ptr] <= {in_sign, in_data} and wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance
  - neither: count unchanged
- Full boundary: in_ready=0, so a simultaneous in_valid and pop performs the pop only; the incoming word is not stored.
- Empty boundary: out_valid=0, so out_ready is ignored. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Overflow: set when in_valid=1 and full=1 at a rising edge. It holds until clear or reset and does not block further operation.
- Clear:
  - Has priority over push and pop in the same cycle.
  - Zeroes pointers, count and overflow.
  - Any push or pop in that cycle is dropped.
- Pointer wrap: both pointers wrap from DEPTH-1 to 0. Empty versus full is resolved by count, not by pointer equality.
- Invariants:
  - count never exceeds DEPTH and never underflows.
  - out_data/out_sign are held stable while out_valid=1 and out_ready=0.
  - in_data and in_sign are not interpreted; any signed/unsigned meaning belongs to the producer.

Decomposition:
- Shared package:
  - constants RESULT_WIDTH=8 and RESULT_DEPTH=4
  - typedef result_entry_t = {sign, data[7:0]}, 9 bits
  - the package is reused by the arithmetic stage and the consumer
- Sub-module result_store:
  - DEPTH x (WIDTH+1) register array
  - one write port (we, waddr, wdata), one asynchronous read port
  - no reset on storage
- result_fifo holds pointers, count, flags and the handshake logic.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles, release.
   - Required: count=0, empty=1, full=0, in_ready=1, out_valid=0, overflow=0.
2. Fill to full: push 0x29/s0, 0x01/s0, 0xBA/s1, 0x4A/s0 with out_ready=0.
   - Required: count=4, full=1, in_ready=0.
   - Required: out_data=0x29, out_sign=0, stable throughout.
3. Overflow: from full, drive in_valid with 0x55 for 1 cycle.
   - Required: overflow=1, count stays 4.
   - Then drain with out_ready=1: outputs in order 0x29, 0x01, 0xBA (sign=1), 0x4A; empty=1 after the 4th pop; 0x55 never appears.
4. Simultaneous push/pop with wrap: hold 2 entries, then push and pop together for 6 cycles, feeding values 0x10..0x15.
   - Required: count stays 2.
   - Required: outputs follow push order across pointer wrap with no loss or duplication.
5. Full plus simultaneous events: at full, in_valid=1 and out_ready=1 in the same cycle.
   - Required: one entry popped, count=3, incoming word not stored, overflow=1.
6. Clear and async reset mid-stream:
   - Hold 3 entries, assert clear together with a push: count=0, empty=1, overflow=0 on the next cycle.
   - Refill 2 entries, pulse rst low between clock edges: count=0 and out_valid=0 immediately, without waiting for clk.
